// File: rtl/svc_pkg.sv
// Shared types, widths and per-service tariff tables for the service executor.
package svc_pkg;

  localparam int NSVC     = 6;
  localparam int COST_W   = 8;
  localparam int REFUND_W = 6;
  localparam int TIME_W   = 4;
  localparam int IDX_W    = 3;

  // Index returned by lowest_set when no bit of the mask is set
  localparam logic [IDX_W-1:0] NONE_IDX = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REFUND = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Services come in pairs sharing one tariff row
  localparam logic [COST_W-1:0]   SVC_COST  [NSVC] = '{8'd20, 8'd20, 8'd30, 8'd30, 8'd10, 8'd10};
  localparam logic [TIME_W-1:0]   SVC_TIME  [NSVC] = '{4'd5, 4'd5, 4'd7, 4'd7, 4'd3, 4'd3};
  localparam logic [COST_W-1:0]   SVC_SURCH [NSVC] = '{8'd2, 8'd2, 8'd3, 8'd3, 8'd1, 8'd1};
  localparam logic [TIME_W-1:0]   SVC_PTIME [NSVC] = '{4'd4, 4'd4, 4'd6, 4'd6, 4'd2, 4'd2};
  localparam logic [REFUND_W-1:0] SVC_REFUND[NSVC] = '{6'd10, 6'd10, 6'd15, 6'd15, 6'd5, 6'd5};

  // Lowest set index of a service mask, NONE_IDX when the mask is empty
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NSVC-1:0] mask);
    logic [IDX_W-1:0] r;
    r = NONE_IDX;
    for (int i = NSVC - 1; i >= 0; i--) begin
      if (mask[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/svc_tariff.sv
// Combinational tariff lookup: service index plus priority mode to cost, time and refund.
module svc_tariff import svc_pkg::*; (
  input  logic [IDX_W-1:0]    idx,
  input  logic                prio,
  output logic [COST_W-1:0]   cost,
  output logic [TIME_W-1:0]   svc_time,
  output logic [REFUND_W-1:0] refund
);

  // Table lookup; out-of-range indices read as an empty tariff
  always_comb begin
    cost     = 8'd0;
    svc_time = 4'd0;
    refund   = 6'd0;
    if (idx < 3'd6) begin
      cost     = prio ? (SVC_COST[idx] + SVC_SURCH[idx]) : SVC_COST[idx];
      svc_time = prio ? SVC_PTIME[idx] : SVC_TIME[idx];
      refund   = SVC_REFUND[idx];
    end else begin
      cost     = 8'd0;
      svc_time = 4'd0;
      refund   = 6'd0;
    end
  end

endmodule

// File: rtl/svc_executor.sv
// Service executor: runs each selected service in turn, bills completed
// services and totals the refund of unfinished services on cancel.
module svc_executor import svc_pkg::*; #(
  parameter int TICK_DIV = 1,
  parameter int IDLE_SVC = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [5:0]          sel,
  input  logic                prio,
  input  logic                cancel,
  output logic                busy,
  output logic [2:0]          cur_svc,
  output logic [3:0]          time_left,
  output logic                svc_done,
  output logic                done,
  output logic                cancelled,
  output logic [7:0]          billed,
  output logic [5:0]          refund
);

  localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDLE_IDX = IDX_W'(IDLE_SVC);

  state_t                state_r, state_nx;
  logic [NSVC-1:0]       pend_r;
  logic                  prio_r;
  logic [IDX_W-1:0]      cur_r;
  logic [TIME_W-1:0]     tleft_r;
  logic [COST_W-1:0]     cost_r;      // cost of the running service, captured at load
  logic [DIV_W-1:0]      div_r;
  logic [IDX_W-1:0]      scan_r;
  logic [COST_W-1:0]     billed_r;
  logic [REFUND_W-1:0]   refund_r;
  logic                  cancelled_r;
  logic                  svc_done_r;

  logic                  tick_s;
  logic                  complete_s;
  logic [NSVC-1:0]       rest_s;
  logic [IDX_W-1:0]      look_idx_s;
  logic                  look_prio_s;
  logic [COST_W-1:0]     cost_s;
  logic [TIME_W-1:0]     svc_time_s;
  logic [REFUND_W-1:0]   refund_amt_s;

  // Single shared lookup: next service to load in IDLE/RUN, scanned index in REFUND
  svc_tariff u_tariff (
    .idx      (look_idx_s),
    .prio     (look_prio_s),
    .cost     (cost_s),
    .svc_time (svc_time_s),
    .refund   (refund_amt_s)
  );

  // Tick, completion and next-service selection
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    complete_s = (state_r == RUN) && tick_s && (tleft_r == 4'd1);
    rest_s     = pend_r & ~(6'b000001 << cur_r);
    if (state_r == IDLE) begin
      look_idx_s  = lowest_set(sel);
      look_prio_s = prio;
    end else if (state_r == REFUND) begin
      look_idx_s  = scan_r;
      look_prio_s = prio_r;
    end else begin
      look_idx_s  = lowest_set(rest_s);
      look_prio_s = prio_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Next-state logic; completion takes precedence over cancel
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx = (sel != 6'd0) ? RUN : DONE;
        else       state_nx = IDLE;
      end
      RUN: begin
        if (complete_s) begin
          if (rest_s == 6'd0) state_nx = DONE;
          else if (cancel)    state_nx = REFUND;
          else                state_nx = RUN;
        end else if (cancel) begin
          state_nx = REFUND;
        end else begin
          state_nx = RUN;
        end
      end
      REFUND: begin
        if (scan_r == 3'd5) state_nx = DONE;
        else                state_nx = REFUND;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      IDLE:    begin busy = 1'b0; done = 1'b0; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      RUN:     begin busy = 1'b1; done = 1'b0; end
      REFUND:  begin busy = 1'b1; done = 1'b0; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Datapath: latching, service countdown, billing and refund accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r      <= 6'd0;
      prio_r      <= 1'b0;
      cur_r       <= IDLE_IDX;
      tleft_r     <= 4'd0;
      cost_r      <= 8'd0;
      div_r       <= '0;
      scan_r      <= 3'd0;
      billed_r    <= 8'd0;
      refund_r    <= 6'd0;
      cancelled_r <= 1'b0;
      svc_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          svc_done_r <= 1'b0;
          if (start) begin
            pend_r      <= sel;
            prio_r      <= prio;
            billed_r    <= 8'd0;
            refund_r    <= 6'd0;
            cancelled_r <= 1'b0;
            div_r       <= '0;
            scan_r      <= 3'd0;
            cost_r      <= cost_s;
            cur_r       <= (sel != 6'd0) ? look_idx_s : IDLE_IDX;
            tleft_r     <= (sel != 6'd0) ? svc_time_s : 4'd0;
          end
        end
        RUN: begin
          svc_done_r <= complete_s;
          div_r      <= tick_s ? '0 : (div_r + DIV_W'(1));
          if (complete_s) begin
            billed_r <= billed_r + cost_r;
            pend_r   <= rest_s;
            if ((rest_s == 6'd0) || cancel) begin
              // Run ends here; a cancel only counts if services remain
              cur_r       <= IDLE_IDX;
              tleft_r     <= 4'd0;
              cancelled_r <= (rest_s != 6'd0);
            end else begin
              // Back-to-back load of the next service on the same edge
              cur_r   <= look_idx_s;
              tleft_r <= svc_time_s;
              cost_r  <= cost_s;
            end
          end else if (cancel) begin
            cancelled_r <= 1'b1;
            cur_r       <= IDLE_IDX;
            tleft_r     <= 4'd0;
          end else if (tick_s) begin
            tleft_r <= tleft_r - 4'd1;
          end
        end
        REFUND: begin
          svc_done_r <= 1'b0;
          scan_r     <= scan_r + 3'd1;
          if (pend_r[scan_r]) refund_r <= refund_r + refund_amt_s;
        end
        DONE: begin
          svc_done_r <= 1'b0;
        end
        default: begin
          svc_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign cur_svc   = cur_r;
  assign time_left = tleft_r;
  assign svc_done  = svc_done_r;
  assign cancelled = cancelled_r;
  assign billed    = billed_r;
  assign refund    = refund_r;

endmodule

// File: tb/tb_svc_executor.sv
// Scoreboard testbench for svc_executor (TICK_DIV=1 instance plus a TICK_DIV=3 instance).
module tb_svc_executor;

  localparam int TB_COST [6] = '{20, 20, 30, 30, 10, 10};
  localparam int TB_TIME [6] = '{5, 5, 7, 7, 3, 3};
  localparam int TB_SUR  [6] = '{2, 2, 3, 3, 1, 1};
  localparam int TB_PTIM [6] = '{4, 4, 6, 6, 2, 2};
  localparam int TB_REF  [6] = '{10, 10, 15, 15, 5, 5};

  typedef struct { int cyc; int bill; } svc_exp_t;
  typedef struct { int cyc; int bill; int refund; int canc; } res_exp_t;

  svc_exp_t svc_q[$];
  res_exp_t res_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst, start, prio, cancel;
  logic [5:0] sel;
  logic busy, svc_done, done, cancelled;
  logic [2:0] cur_svc;
  logic [3:0] time_left;
  logic [7:0] billed;
  logic [5:0] refund;

  logic rst3, start3, prio3, cancel3;
  logic [5:0] sel3;
  logic busy3, svc_done3, done3, cancelled3;
  logic [2:0] cur_svc3;
  logic [3:0] time_left3;
  logic [7:0] billed3;
  logic [5:0] refund3;

  always #5 clk = ~clk;

  svc_executor #(.TICK_DIV(1), .IDLE_SVC(7)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .prio(prio), .cancel(cancel),
    .busy(busy), .cur_svc(cur_svc), .time_left(time_left), .svc_done(svc_done),
    .done(done), .cancelled(cancelled), .billed(billed), .refund(refund)
  );

  svc_executor #(.TICK_DIV(3), .IDLE_SVC(7)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .sel(sel3), .prio(prio3), .cancel(cancel3),
    .busy(busy3), .cur_svc(cur_svc3), .time_left(time_left3), .svc_done(svc_done3),
    .done(done3), .cancelled(cancelled3), .billed(billed3), .refund(refund3)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: pushes expected completions and the final result
  task automatic model(input logic [5:0] s, input logic p, input int cancel_at);
    int t, bill, rf, canc, done_k, tm;
    logic [5:0] pend;
    svc_exp_t e;
    res_exp_t r;
    t = 0; bill = 0; rf = 0; canc = 0; done_k = -1; pend = s;
    if (s == 6'd0) done_k = 0;
    for (int i = 0; i < 6; i++) begin
      if (pend[i] && done_k < 0) begin
        tm = p ? TB_PTIM[i] : TB_TIME[i];
        if (cancel_at >= 1 && cancel_at < t + tm) begin
          canc = 1;
          for (int j = 0; j < 6; j++) if (pend[j]) rf += TB_REF[j];
          done_k = cancel_at + 6;
        end else begin
          t += tm;
          bill += TB_COST[i] + (p ? TB_SUR[i] : 0);
          pend[i] = 1'b0;
          e.cyc = t; e.bill = bill;
          svc_q.push_back(e);
          if (pend == 6'd0) done_k = t;
          else if (cancel_at == t) begin
            canc = 1;
            for (int j = 0; j < 6; j++) if (pend[j]) rf += TB_REF[j];
            done_k = t + 6;
          end
        end
      end
    end
    r.cyc = done_k; r.bill = bill; r.refund = rf; r.canc = canc;
    res_q.push_back(r);
  endtask

  function automatic int lowest(input logic [5:0] s);
    int r;
    r = 7;
    for (int i = 5; i >= 0; i--) if (s[i]) r = i;
    return r;
  endfunction

  // One transaction on the TICK_DIV=1 instance; cycle k counts edges after acceptance
  task automatic run_case(input logic [5:0] s, input logic p, input int cancel_at, input int start_at);
    bit finished;
    svc_exp_t e;
    res_exp_t r;
    int lo;
    model(s, p, cancel_at);
    @(negedge clk);
    check("idle_before", int'(busy), 0);
    start = 1'b1; sel = s; prio = p; cancel = 1'b0;
    @(posedge clk);
    finished = 0;
    for (int k = 0; k < 120 && !finished; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; sel = ~s; prio = ~p;
        check("busy_run", int'(busy), 1);
        if (s != 6'd0) begin
          lo = lowest(s);
          check("first_svc", int'(cur_svc), lo);
          check("first_time", int'(time_left), p ? TB_PTIM[lo] : TB_TIME[lo]);
        end
      end
      if (svc_done) begin
        if (svc_q.size() == 0) check("svc_extra", 1, 0);
        else begin
          e = svc_q.pop_front();
          check("svc_cyc", k, e.cyc);
          check("svc_bill", int'(billed), e.bill);
        end
      end
      if (done) begin
        r = res_q.pop_front();
        check("done_cyc", k, r.cyc);
        check("billed", int'(billed), r.bill);
        check("refund", int'(refund), r.refund);
        check("cancelled", int'(cancelled), r.canc);
        check("cur_idle", int'(cur_svc), 7);
        check("svc_missing", svc_q.size(), 0);
        finished = 1;
      end else begin
        cancel = (k + 1 == cancel_at);
        start  = (k + 1 == start_at);
      end
    end
    cancel = 1'b0; start = 1'b0;
    if (!finished) check("timeout", 0, 1);
    svc_q.delete();
    res_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin3;
    int svc_k;
    logic [5:0] rs;
    rst = 1'b1; rst3 = 1'b1;
    start = 1'b0; sel = 6'd0; prio = 1'b0; cancel = 1'b0;
    start3 = 1'b0; sel3 = 6'd0; prio3 = 1'b0; cancel3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst3 = 1'b0;

    // Reset values
    check("rst_busy", int'(busy), 0);
    check("rst_cur", int'(cur_svc), 7);
    check("rst_time", int'(time_left), 0);
    check("rst_done", int'(done), 0);
    check("rst_svcdone", int'(svc_done), 0);
    check("rst_billed", int'(billed), 0);
    check("rst_refund", int'(refund), 0);
    check("rst_canc", int'(cancelled), 0);

    run_case(6'b000001, 1'b0, -1, -1);   // single service
    run_case(6'b111111, 1'b0, -1, -1);   // all services, normal
    run_case(6'b111111, 1'b1, -1, -1);   // all services, priority
    run_case(6'b001101, 1'b0, 8, -1);    // cancel 3 cycles into service 2
    run_case(6'b000000, 1'b0, -1, -1);   // empty mask
    run_case(6'b000001, 1'b0, 5, -1);    // cancel on last completing edge
    run_case(6'b100001, 1'b1, 4, -1);    // cancel on completing edge with work left
    run_case(6'b000110, 1'b0, -1, 3);    // start pulsed mid-run
    for (int n = 0; n < 6; n++) begin
      rs = 6'($urandom_range(0, 63));
      run_case(rs, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1, -1);
    end
    @(negedge clk);
    check("idle_after", int'(busy), 0);

    // TICK_DIV=3 instance: reset mid-run, then a full run
    @(negedge clk);
    start3 = 1'b1; sel3 = 6'b010000; prio3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("d3_busy", int'(busy3), 1);
    check("d3_cur", int'(cur_svc3), 4);
    check("d3_time", int'(time_left3), 2);
    rst3 = 1'b1;
    #1;
    check("d3_rst_busy", int'(busy3), 0);
    check("d3_rst_cur", int'(cur_svc3), 7);
    check("d3_rst_time", int'(time_left3), 0);
    check("d3_rst_done", int'(done3), 0);
    check("d3_rst_billed", int'(billed3), 0);
    repeat (2) begin
      @(negedge clk);
      check("d3_no_done", int'(done3), 0);
    end
    rst3 = 1'b0;
    @(negedge clk);
    check("d3_post_busy", int'(busy3), 0);
    check("d3_post_done", int'(done3), 0);
    start3 = 1'b1;
    @(posedge clk);
    fin3 = 0; svc_k = -1;
    for (int k = 0; k < 40 && !fin3; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (svc_done3) svc_k = k;
      if (done3) begin
        check("d3_done_cyc", k, 9);
        check("d3_svc_cyc", svc_k, 9);
        check("d3_billed", int'(billed3), 10);
        fin3 = 1;
      end
    end
    if (!fin3) check("d3_timeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
